dmem_store_unit: RTL



---
 rtl/dmem_pkg.sv | 49 ++++
 rtl/dmem_store_unit_if.sv | 42 ++++
 rtl/store_merge.sv | 42 ++++
 rtl/dmem_store_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory store unit:
//   size_e     - store size, same encoding as the control unit's tam field
//   state_e    - store FSM states
//   BYTE_LANES - byte lanes in one memory word
//   align_off / is_misaligned - offset helpers used by the FSM and merge logic
package dmem_pkg;

    localparam int BYTE_LANES = 8;

    typedef enum logic [1:0] {
        SZ_D = 2'b00,
        SZ_W = 2'b01,
        SZ_H = 2'b10,
        SZ_B = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        DONE
    } state_e;

    // Force the byte offset down to the natural alignment of the access size.
    function automatic logic [2:0] align_off(input size_e sz, input logic [2:0] off);
        logic [2:0] r;
        case (sz)
            SZ_W:    r = {off[2], 2'b00};
            SZ_H:    r = {off[2:1], 1'b0};
            SZ_B:    r = off;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [2:0] off);
        logic r;
        case (sz)
            SZ_D:    r = (off != 3'd0);
            SZ_W:    r = (off[1:0] != 2'd0);
            SZ_H:    r = off[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_store_unit_if.sv
// dmem_store_unit_if
// Request and memory-side signals of the store unit.
//   req/tam/addr/wdata   - store command from the control unit / datapath
//   busy/done            - status back to the control unit
//   misalign             - trap pulse, present only with STORE_MISALIGN_TRAP_EN
//   mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata - word-organised data memory
// Modports: slave = the store unit, master = requester plus memory.
interface dmem_store_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req;
    logic [1:0]        tam;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wdata;
    logic              busy;
    logic              done;
`ifdef STORE_MISALIGN_TRAP_EN
    logic              misalign;
`endif
    logic [ADDR_W-4:0] mem_addr;
    logic              mem_rd;
    logic [63:0]       mem_rdata;
    logic              mem_wr;
    logic [63:0]       mem_wdata;

    modport slave (
        input  req, tam, addr, wdata, mem_rdata,
        output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata
`ifdef STORE_MISALIGN_TRAP_EN
        , output misalign
`endif
    );

    modport master (
        output req, tam, addr, wdata, mem_rdata,
        input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata
`ifdef STORE_MISALIGN_TRAP_EN
        , input misalign
`endif
    );

endinterface

// File: rtl/store_merge.sv
// store_merge
// Combinational byte-lane merge for sub-word stores.
//   old_word - word read back from memory
//   wdata    - store data, low bytes used
//   size     - store size (size_e)
//   offset   - byte offset within the word, aligned here to the size
//   merged   - old_word with the selected lanes replaced (lane 0 = bits [7:0])
module store_merge
    import dmem_pkg::*;
(
    input  logic [63:0] old_word,
    input  logic [63:0] wdata,
    input  size_e       size,
    input  logic [2:0]  offset,
    output logic [63:0] merged
);

    logic [2:0] aoff;
    logic [3:0] nbytes;
    logic [2:0] j;

    always_comb begin
        aoff   = align_off(size, offset);
        nbytes = 4'd8;
        case (size)
            SZ_W:    nbytes = 4'd4;
            SZ_H:    nbytes = 4'd2;
            SZ_B:    nbytes = 4'd1;
            default: nbytes = 4'd8;
        endcase
        merged = old_word;
        j      = 3'd0;
        for (int i = 0; i < BYTE_LANES; i++) begin
            // Modulo-8 distance from the first replaced lane; lanes below aoff
            // wrap to >= 8-aoff, which is never < nbytes for aligned offsets.
            j = 3'(i) - aoff;
            if ({1'b0, j} < nbytes)
                merged[8*i +: 8] = wdata[8*j +: 8];
        end
    end

endmodule

// File: rtl/dmem_store_unit.sv
// dmem_store_unit
// Store responder between the multicycle control unit and the data memory.
// sd writes the word directly; sw/sh/sb read the word, merge the new lanes
// and write it back (RD -> MRG -> WR -> DONE).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - dmem_store_unit_if.slave (request, status and memory signals)
// Optional feature: define STORE_MISALIGN_TRAP_EN to drop misaligned
// requests with a one-cycle misalign/done pulse instead of force-aligning.
module dmem_store_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input logic               clk,
    input logic               reset,
    dmem_store_unit_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             tam_q, tam_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       wword_q, wword_d;
    logic [63:0]       merged;
`ifdef STORE_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    store_merge u_merge (
        .old_word (bus.mem_rdata),
        .wdata    (wdata_q),
        .size     (tam_q),
        .offset   (addr_q[2:0]),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tam_d   = tam_q;
        wdata_d = wdata_q;
        wword_d = wword_q;
`ifdef STORE_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    tam_d   = size_e'(bus.tam);
                    wdata_d = bus.wdata;
`ifdef STORE_MISALIGN_TRAP_EN
                    misalign_d = is_misaligned(size_e'(bus.tam), bus.addr[2:0]);
                    if (misalign_d) begin
                        state_d = DONE;
                    end else
`endif
                    if (size_e'(bus.tam) == SZ_D) begin
                        wword_d = bus.wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = MRG;
            MRG: begin
                // Read data is valid this cycle only; capture the merge now.
                wword_d = merged;
                state_d = WR;
            end
            WR:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tam_q   <= SZ_D;
            wdata_q <= '0;
            wword_q <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tam_q   <= tam_d;
            wdata_q <= wdata_d;
            wword_q <= wword_d;
`ifdef STORE_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Moore outputs: strobes come from state alone, so an asynchronous reset
    // removes them immediately.
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.mem_rd    = (state_q == RD);
    assign bus.mem_wr    = (state_q == WR);
    assign bus.mem_addr  = addr_q[ADDR_W-1:3];
    assign bus.mem_wdata = wword_q;
`ifdef STORE_MISALIGN_TRAP_EN
    assign bus.misalign  = (state_q == DONE) && misalign_q;
`endif

endmodule
